// File: rtl/shift_engine.sv
// shift_engine: multi-cycle universal shift register (load / SLL / SRL / ROR).
// Each bit's next state is a 4:1 pick of hold, load, left neighbour or right
// neighbour. A small IDLE/RUN/DONE FSM drives that pick, one step per clock.
module shift_engine #(
  parameter int W     = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [W-1:0]     data_in,
  input  logic             serial_in,
  output logic             ready,
  output logic             done,
  output logic [W-1:0]     q,
  output logic             serial_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  // Per-bit source select codes; the values index the 4:1 candidate vector.
  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_LOAD  = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;
  localparam logic [1:0] SEL_RIGHT = 2'd3;

  state_t           state_reg, state_next;
  logic [W-1:0]     q_reg;
  logic [W-1:0]     q_next;
  logic             so_reg, so_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic [1:0]       sel;
  logic             fill_hi;

  // The MSB's right neighbour is the wrapped LSB for rotate, otherwise the serial fill.
  assign fill_hi = (op_reg == OP_ROR) ? q_reg[0] : serial_in;

  // Per-bit 4:1 next-state selection; bit 0 takes serial_in as its left neighbour.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic       left_src;
      logic       right_src;
      logic [3:0] cand;
      if (gi == 0) begin : g_lsb
        assign left_src = serial_in;
      end else begin : g_lmid
        assign left_src = q_reg[gi-1];
      end
      if (gi == W-1) begin : g_msb
        assign right_src = fill_hi;
      end else begin : g_rmid
        assign right_src = q_reg[gi+1];
      end
      assign cand      = {right_src, left_src, data_in[gi], q_reg[gi]};
      assign q_next[gi] = cand[sel];
    end
  endgenerate

  // Next-state, bit-select and serial_out logic for the command FSM.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    so_next    = so_reg;
    sel        = SEL_HOLD;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next = op;
          if (op == OP_LOAD) begin
            sel        = SEL_LOAD;
            state_next = DONE;
          end else if (amount == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = amount;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (op_reg == OP_SLL) begin
          sel     = SEL_LEFT;
          so_next = q_reg[W-1];
        end else begin
          sel     = SEL_RIGHT;
          so_next = q_reg[0];
        end
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == AMT_W'(1)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      so_reg    <= 1'b0;
      cnt_reg   <= '0;
      op_reg    <= OP_LOAD;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      so_reg    <= so_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  assign ready      = (state_reg == IDLE);
  assign done       = (state_reg == DONE);
  assign q          = q_reg;
  assign serial_out = so_reg;

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: directed plus randomized commands against an arithmetic model.
module tb_shift_engine;
  localparam int W     = 8;
  localparam int AMT_W = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amount;
  logic [W-1:0]     data_in;
  logic             serial_in;
  logic             ready;
  logic             done;
  logic [W-1:0]     q;
  logic             serial_out;

  int n_tests = 0;
  int n_fail  = 0;
  int m_q     = 0;   // model register value, 0..255
  int m_so    = 0;   // model serial_out

  shift_engine #(.W(W), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
    .data_in(data_in), .serial_in(serial_in), .ready(ready), .done(done),
    .q(q), .serial_out(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One shift step on the model, written as plain arithmetic on an 8-bit value.
  task automatic model_step(input int cop, input int si);
    if (cop == 1) begin
      m_so = m_q / 128;
      m_q  = (m_q * 2 + si) % 256;
    end else if (cop == 2) begin
      m_so = m_q % 2;
      m_q  = m_q / 2 + si * 128;
    end else begin
      m_so = m_q % 2;
      m_q  = m_q / 2 + m_so * 128;
    end
  endtask

  // Issue one command and check every cycle until ready returns.
  // si_mode: 0/1 constant fill, 2 random fill per step. noise: hammer start with load 0xFF during RUN.
  task automatic run_cmd(input int cop, input int camt, input int cdata, input int si_mode, input bit noise);
    int si;
    @(negedge clk);
    check("ready_before_accept", 32'(ready), 32'd1);
    start     = 1'b1;
    op        = cop[1:0];
    amount    = camt[AMT_W-1:0];
    data_in   = cdata[W-1:0];
    serial_in = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    if (cop == 0) m_q = cdata % 256;
    if (cop == 0 || camt == 0) begin
      check("done_after_accept", 32'(done), 32'd1);
      check("ready_after_accept", 32'(ready), 32'd0);
      check("q_after_accept", 32'(q), 32'(m_q));
      check("so_after_accept", 32'(serial_out), 32'(m_so));
    end else begin
      check("run_ready_low", 32'(ready), 32'd0);
      check("run_done_low", 32'(done), 32'd0);
      check("q_at_accept", 32'(q), 32'(m_q));
      for (int i = 1; i <= camt; i++) begin
        si = (si_mode == 2) ? int'($urandom_range(0, 1)) : si_mode;
        serial_in = si[0];
        if (noise) begin
          start = 1'b1; op = 2'b00; data_in = 8'hFF; amount = AMT_W'($urandom);
        end else begin
          start = 1'($urandom_range(0, 1)); op = 2'($urandom);
          data_in = W'($urandom); amount = AMT_W'($urandom);
        end
        @(negedge clk);
        model_step(cop, si);
        check($sformatf("step%0d_q", i), 32'(q), 32'(m_q));
        check($sformatf("step%0d_so", i), 32'(serial_out), 32'(m_so));
        check($sformatf("step%0d_done", i), 32'(done), (i == camt) ? 32'd1 : 32'd0);
        check($sformatf("step%0d_ready", i), 32'(ready), 32'd0);
      end
    end
    // A load offered during the DONE cycle must be ignored.
    start   = 1'b1;
    op      = 2'b00;
    data_in = W'(~m_q);
    @(negedge clk);
    start = 1'b0;
    check("post_done_low", 32'(done), 32'd0);
    check("post_ready_high", 32'(ready), 32'd1);
    check("post_q_hold", 32'(q), 32'(m_q));
    $display("[TB] cmd op=%0d amt=%0d data=%02h -> q=%02h so=%0b", cop, camt, cdata, q, serial_out);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; amount = '0; data_in = '0; serial_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'h00);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_so", 32'(serial_out), 32'd0);
    reset = 1'b1;

    run_cmd(0, 0, 8'hA5, 0, 1'b0);
    check("load_a5_const", 32'(q), 32'hA5);
    run_cmd(3, 3, 0, 2, 1'b0);
    check("ror3_const", 32'(q), 32'hB4);
    check("ror3_so_const", 32'(serial_out), 32'd1);
    run_cmd(0, 0, 8'hA5, 0, 1'b0);
    run_cmd(1, 4, 0, 1, 1'b0);
    check("sll4_const", 32'(q), 32'h5F);
    check("sll4_so_const", 32'(serial_out), 32'd0);
    run_cmd(2, 2, 0, 0, 1'b0);
    check("srl2_const", 32'(q), 32'h17);
    check("srl2_so_const", 32'(serial_out), 32'd1);
    run_cmd(1, 0, 0, 2, 1'b0);
    check("amt0_const", 32'(q), 32'h17);
    run_cmd(0, 0, 8'h3C, 0, 1'b0);
    run_cmd(3, 8, 0, 2, 1'b1);
    check("ror8_const", 32'(q), 32'h3C);

    // Reset in the middle of a RUN aborts immediately with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b11; amount = AMT_W'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_q", 32'(q), 32'h00);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("midrst_done_later", 32'(done), 32'd0);
    reset = 1'b1;
    m_q = 0; m_so = 0;
    $display("[TB] reset during RUN -> q=%02h ready=%0b", q, ready);

    run_cmd(2, 15, 0, 1, 1'b0);
    check("srl15_const", 32'(q), 32'hFF);

    for (int k = 0; k < 25; k++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 255)), 2, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
- Multi-cycle universal shift register that consumes the per-bit next-state selection produced by the team's 2:1/4:1 mux stages.
- Accepts a command (load / shift-left / shift-right / rotate-right) plus a step count, then shifts one bit per clock under a start/ready/done handshake.
- Holds the result on q for downstream datapath logic.
- Each bit's next-state is a 4:1 selection between hold, load, left-neighbour and right-neighbour, driven by the FSM.

Parameters:
- W, 8, data width in bits (>= 2).
- AMT_W, 4, width of the shift-count field.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command request; accepted only when ready=1.
- op  input  2  00 load, 01 shift left logical (SLL), 10 shift right logical (SRL), 11 rotate right (ROR).
- amount  input  AMT_W  number of single-bit steps; ignored for load.
- data_in  input  W  parallel load value.
- serial_in  input  1  fill bit for SLL/SRL.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse when the command completes.
- q  output  W  register contents.
- serial_out  output  1  registered copy of the last bit shifted or rotated out.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, q=0, serial_out=0, done=0, ready=1, counter=0. Reset asserted at any point, including mid-RUN, aborts the command immediately; no done is produced.
- FSM states: IDLE, RUN, DONE. ready = (state==IDLE); done = (state==DONE).
- IDLE:
  - start=1 at edge k accepts the command; op and amount are latched.
  - op=00: q <= data_in at edge k; go to DONE.
  - Shift ops with amount=0: q and serial_out unchanged; go to DONE.
  - Shift ops with amount=n>0: counter <= n; go to RUN.
- RUN, one step per edge:
  - SLL: q <= {q[W-2:0], serial_in}; serial_out <= q[W-1].
  - SRL: q <= {serial_in, q[W-1:1]}; serial_out <= q[0].
  - ROR: q <= {q[0], q[W-1:1]}; serial_out <= q[0]. serial_in is ignored.
  - Each step decrements counter. The step taken with counter==1 also moves the FSM to DONE.
  - serial_in is sampled at every step edge.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- Timing: for n>0, steps occur at edges k+1..k+n, done is high in the cycle after edge k+n, and ready=1 again after edge k+n+1. Load and amount=0 complete with done in the cycle after edge k.
- start is ignored whenever ready=0, including during the DONE cycle. Inputs may change freely during RUN; only the latched op/amount and the live serial_in are used.
- amount > W is legal:
  - SLL/SRL with constant serial_in saturate q to all serial_in.
  - ROR wraps modulo W.
- q holds its value in IDLE and DONE.

Test Plan (W=8, AMT_W=4):
- Reset then load: hold reset=0, check q=0x00, ready=1, done=0; release; start, op=00, data_in=0xA5 -> q=0xA5 after the accept edge; done=1 for exactly 1 cycle; ready=1 the cycle after done.
- ROR by 3 from q=0xA5 -> q=0xB4 after 3 RUN edges; serial_out=1; done pulses once; ready low for 4 cycles after accept.
- SLL by 4 with serial_in=1 from 0xA5 -> q=0x5F, serial_out=0. Then SRL by 2 with serial_in=0 -> q=0x17, serial_out=1.
- amount=0 with op=01 from q=0x17 -> q stays 0x17; done in the cycle after accept; no RUN cycles.
- Mid-run events:
  - Start ROR by 8 from 0x3C and pulse start with op=00, data_in=0xFF during RUN -> second command ignored; final q=0x3C; single done.
  - Assert reset during RUN -> q=0x00, ready=1 immediately; no done pulse.
- SRL by 15 with serial_in=1 from 0x00 -> q=0xFF; done in the cycle after the 15th step edge.
